// File: rtl/int_responder_if.sv
// ---------------------------------------------------------------------------
// int_responder_if
//   Bundles the trigger-load handshake, the CPU-side observation buses and
//   the interrupt/status outputs of int_responder into one interface.
//
//   Signals:
//     arm_valid      trigger load request valid           (to responder)
//     arm_ready      responder accepts a load             (from responder)
//     arm_pc[31:0]   trigger PC                           (to responder)
//     arm_repeat[3:0] number of interrupts minus 1        (to responder)
//     macroscopic_pc[31:0] committed PC from the CPU      (to responder)
//     m_int_addr[31:0]     ack write address from the CPU (to responder)
//     m_int_byteen[3:0]    ack write byte enables         (to responder)
//     interrupt      registered interrupt request         (from responder)
//     busy           responder not idle                   (from responder)
//     ack_count[7:0] accepted acks, wrapping              (from responder)
//     timeout_err    sticky abort flag                    (from responder)
//
//   Modports:
//     slave  - the responder itself
//     master - the environment (CPU shell / testbench)
// ---------------------------------------------------------------------------
interface int_responder_if;

    logic        arm_valid;
    logic        arm_ready;
    logic [31:0] arm_pc;
    logic [3:0]  arm_repeat;
    logic [31:0] macroscopic_pc;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        interrupt;
    logic        busy;
    logic [7:0]  ack_count;
    logic        timeout_err;

    modport slave (
        input  arm_valid,
        input  arm_pc,
        input  arm_repeat,
        input  macroscopic_pc,
        input  m_int_addr,
        input  m_int_byteen,
        output arm_ready,
        output interrupt,
        output busy,
        output ack_count,
        output timeout_err
    );

    modport master (
        output arm_valid,
        output arm_pc,
        output arm_repeat,
        output macroscopic_pc,
        output m_int_addr,
        output m_int_byteen,
        input  arm_ready,
        input  interrupt,
        input  busy,
        input  ack_count,
        input  timeout_err
    );

endinterface

// File: rtl/int_responder.sv
// ---------------------------------------------------------------------------
// int_responder
//   External interrupt source with acknowledge detection. Once armed with a
//   trigger PC, it raises `interrupt` when the CPU's committed PC reaches
//   that address and holds it until the CPU writes the interrupt-acknowledge
//   word. After each ack it cools down for GAP cycles and re-arms, for a
//   programmed number of occurrences (arm_repeat + 1).
//
//   Parameters:
//     INT_ADDR  interrupt-acknowledge word address (bits [1:0] ignored)
//     GAP       cooldown cycles after each ack, 0..255
//     TIMEOUT   ASSERT cycles without ack before abort, 1..65535
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    int_responder_if.slave (handshake, CPU buses, status outputs)
//
//   Build option:
//     INT_RESP_TIMEOUT_EN  when defined, builds the ASSERT timeout counter
//                          and the sticky timeout_err flag. When undefined,
//                          ASSERT waits for an ack forever, timeout_err is
//                          tied low and TIMEOUT is unused.
// ---------------------------------------------------------------------------
module int_responder #(
    parameter logic [31:0] INT_ADDR = 32'h0000_7F20,
    parameter int unsigned GAP      = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input logic               clk,
    input logic               reset,
    int_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ASSERT = 2'd2,
        S_GAP    = 2'd3
    } state_e;

    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  rem_q, rem_d;
    // Whether another occurrence follows the current cooldown; captured at
    // the ack because rem has already been decremented by then.
    logic        more_q, more_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  ack_cnt_q, ack_cnt_d;
    logic        irq_q, irq_d;

    logic        ack_hit;
    logic        pc_hit;
    logic        timeout_hit;

    assign ack_hit = (bus.m_int_byteen != 4'b0000) &&
                     (bus.m_int_addr[31:2] == INT_ADDR[31:2]);
    assign pc_hit  = (bus.macroscopic_pc == pc_q);

`ifdef INT_RESP_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt_q, to_cnt_d;
    logic        terr_q, terr_d;

    assign timeout_hit = (to_cnt_q == TO_LAST);

    logic unused_ok;
    assign unused_ok = ^bus.m_int_addr[1:0];
`else
    assign timeout_hit = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{bus.m_int_addr[1:0], (TIMEOUT != 0)};
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rem_d     = rem_q;
        more_d    = more_q;
        gap_cnt_d = gap_cnt_q;
        ack_cnt_d = ack_cnt_q;
`ifdef INT_RESP_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        terr_d    = terr_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.arm_valid) begin
                    pc_d    = bus.arm_pc;
                    rem_d   = bus.arm_repeat;
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                if (pc_hit) begin
                    state_d = S_ASSERT;
`ifdef INT_RESP_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end

            S_ASSERT: begin
                // An ack in the same cycle as the timeout takes priority.
                if (ack_hit) begin
                    ack_cnt_d = ack_cnt_q + 8'd1;
                    if (rem_q != 4'd0) begin
                        rem_d = rem_q - 4'd1;
                    end
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                        more_d    = (rem_q != 4'd0);
                    end else begin
                        state_d = (rem_q != 4'd0) ? S_ARMED : S_IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
`ifdef INT_RESP_TIMEOUT_EN
                    terr_d  = 1'b1;
`endif
                end else begin
`ifdef INT_RESP_TIMEOUT_EN
                    to_cnt_d = to_cnt_q + 16'd1;
`endif
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = more_q ? S_ARMED : S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // interrupt is a registered copy of "next state is ASSERT"
        irq_d = (state_d == S_ASSERT);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            rem_q     <= '0;
            more_q    <= 1'b0;
            gap_cnt_q <= '0;
            ack_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rem_q     <= rem_d;
            more_q    <= more_d;
            gap_cnt_q <= gap_cnt_d;
            ack_cnt_q <= ack_cnt_d;
            irq_q     <= irq_d;
        end
    end

`ifdef INT_RESP_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.interrupt = irq_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.arm_ready = (state_q == S_IDLE);
    assign bus.ack_count = ack_cnt_q;

endmodule

// File: tb/tb_int_responder.sv
// ---------------------------------------------------------------------------
// tb_int_responder
//   Directed testbench for int_responder (GAP=4, TIMEOUT=8). Inputs are
//   driven and outputs sampled on the falling clock edge; the DUT samples on
//   the rising edge. Timeout-specific expectations depend on whether
//   INT_RESP_TIMEOUT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_int_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    int_responder_if bus ();

    int_responder #(
        .INT_ADDR (32'h0000_7F20),
        .GAP      (4),
        .TIMEOUT  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle arm handshake; leaves the bench just after the accepting edge.
    task automatic arm(input logic [31:0] pc, input logic [3:0] rep);
        check("arm_ready_before", bus.arm_ready, 1);
        bus.arm_valid  = 1'b1;
        bus.arm_pc     = pc;
        bus.arm_repeat = rep;
        tick();
        bus.arm_valid  = 1'b0;
        check("arm_busy", bus.busy, 1);
        check("arm_ready_after", bus.arm_ready, 0);
    endtask

    // One-cycle write on the ack port.
    task automatic do_ack(input logic [31:0] addr, input logic [3:0] be);
        bus.m_int_addr   = addr;
        bus.m_int_byteen = be;
        tick();
        bus.m_int_addr   = '0;
        bus.m_int_byteen = '0;
    endtask

    task automatic wait_irq();
        for (int k = 0; k < 20 && bus.interrupt !== 1'b1; k++) tick();
        check("wait_irq", bus.interrupt, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bus.arm_ready !== 1'b1; k++) tick();
        check("wait_idle", bus.arm_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.arm_valid      = 1'b0;
        bus.arm_pc         = '0;
        bus.arm_repeat     = '0;
        bus.macroscopic_pc = '0;
        bus.m_int_addr     = '0;
        bus.m_int_byteen   = '0;

        // ---------------- reset values ----------------
        tick(); tick();
        check("rst_interrupt",   bus.interrupt,   0);
        check("rst_busy",        bus.busy,        0);
        check("rst_arm_ready",   bus.arm_ready,   1);
        check("rst_ack_count",   bus.ack_count,   0);
        check("rst_timeout_err", bus.timeout_err, 0);
        reset = 1'b1;
        tick();

        // ---------------- single shot ----------------
        arm(32'h3008, 4'd0);
        check("ss_armed_irq", bus.interrupt, 0);
        tick(); tick();
        check("ss_armed_wait", bus.interrupt, 0);
        bus.macroscopic_pc = 32'h3008;
        check("ss_match_comb", bus.interrupt, 0);
        tick();
        check("ss_irq_rise", bus.interrupt, 1);
        bus.macroscopic_pc = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ss_irq_hold", bus.interrupt, 1);
        end
        do_ack(32'h7F20, 4'b0001);
        check("ss_irq_fall", bus.interrupt, 0);
        check("ss_ack_count", bus.ack_count, 1);
        check("ss_busy_gap", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ss_gap_busy", bus.busy, 1);
        end
        tick();
        check("ss_idle_busy", bus.busy, 0);
        check("ss_idle_ready", bus.arm_ready, 1);

        // ---------------- repeat=2, PC held at the trigger ----------------
        bus.macroscopic_pc = 32'h4000;
        arm(32'h4000, 4'd2);
        check("rp_arm_irq", bus.interrupt, 0);
        tick();
        check("rp_first_irq", bus.interrupt, 1);
        for (int k = 0; k < 3; k++) begin
            do_ack(32'h7F20, 4'b1111);
            check("rp_ack_irq", bus.interrupt, 0);
            check("rp_ack_count", bus.ack_count, 32'(2 + k));
            if (k < 2) begin
                for (int i = 0; i < 4; i++) begin
                    tick();
                    check("rp_gap_no_irq", bus.interrupt, 0);
                end
                tick();
                check("rp_reassert", bus.interrupt, 1);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check("rp_last_gap_busy", bus.busy, 1);
                end
                tick();
                check("rp_idle", bus.busy, 0);
                check("rp_idle_irq", bus.interrupt, 0);
            end
        end

        // ---------------- spurious / mismatched acks ----------------
        bus.macroscopic_pc = '0;
        arm(32'h5000, 4'd0);
        do_ack(32'h7F20, 4'b0001);
        check("sp_armed_irq", bus.interrupt, 0);
        check("sp_armed_count", bus.ack_count, 4);
        check("sp_armed_busy", bus.busy, 1);
        bus.macroscopic_pc = 32'h5000;
        tick();
        check("sp_irq_rise", bus.interrupt, 1);
        bus.macroscopic_pc = '0;
        do_ack(32'h7F24, 4'b1111);
        check("sp_wrong_addr_irq", bus.interrupt, 1);
        check("sp_wrong_addr_cnt", bus.ack_count, 4);
        do_ack(32'h7F20, 4'b0000);
        check("sp_no_be_irq", bus.interrupt, 1);
        check("sp_no_be_cnt", bus.ack_count, 4);
        do_ack(32'h7F23, 4'b1000);
        check("sp_lowbits_irq", bus.interrupt, 0);
        check("sp_lowbits_cnt", bus.ack_count, 5);
        for (int i = 0; i < 4; i++) tick();
        check("sp_idle", bus.busy, 0);

        // ---------------- ack on the 8th ASSERT cycle ----------------
        bus.macroscopic_pc = 32'h7000;
        arm(32'h7000, 4'd0);
        tick();
        check("bd_irq_rise", bus.interrupt, 1);
        for (int i = 0; i < 7; i++) tick();
        check("bd_irq_before_ack", bus.interrupt, 1);
        do_ack(32'h7F20, 4'b0010);
        check("bd_irq_fall", bus.interrupt, 0);
        check("bd_timeout_err", bus.timeout_err, 0);
        check("bd_ack_count", bus.ack_count, 6);
        for (int i = 0; i < 4; i++) tick();
        check("bd_idle", bus.busy, 0);

        // ---------------- timeout ----------------
        bus.macroscopic_pc = 32'h6000;
`ifdef INT_RESP_TIMEOUT_EN
        arm(32'h6000, 4'd1);
        tick();
        check("to_irq_rise", bus.interrupt, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_irq_hold", bus.interrupt, 1);
        end
        tick();
        check("to_irq_fall", bus.interrupt, 0);
        check("to_err_set", bus.timeout_err, 1);
        check("to_idle", bus.busy, 0);
        check("to_ack_count", bus.ack_count, 6);
        for (int i = 0; i < 3; i++) tick();
        check("to_repeat_dropped", bus.interrupt, 0);
        check("to_still_idle", bus.busy, 0);
        check("to_err_sticky", bus.timeout_err, 1);
`else
        arm(32'h6000, 4'd0);
        tick();
        check("nt_irq_rise", bus.interrupt, 1);
        for (int i = 0; i < 12; i++) tick();
        check("nt_irq_hold", bus.interrupt, 1);
        check("nt_err_tied", bus.timeout_err, 0);
        do_ack(32'h7F20, 4'b0001);
        check("nt_irq_fall", bus.interrupt, 0);
        check("nt_ack_count", bus.ack_count, 7);
        for (int i = 0; i < 4; i++) tick();
        check("nt_idle", bus.busy, 0);
`endif

        // ---------------- async reset mid-ASSERT ----------------
        bus.macroscopic_pc = 32'h8000;
        arm(32'h8000, 4'd0);
        tick();
        check("ar_irq_rise", bus.interrupt, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_interrupt",   bus.interrupt,   0);
        check("ar_busy",        bus.busy,        0);
        check("ar_arm_ready",   bus.arm_ready,   1);
        check("ar_ack_count",   bus.ack_count,   0);
        check("ar_timeout_err", bus.timeout_err, 0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_ready_release", bus.arm_ready, 1);
        check("ar_irq_release", bus.interrupt, 0);

        // ---------------- ack_count wrap 255 -> 0 ----------------
        bus.macroscopic_pc = 32'h9000;
        for (int n = 0; n < 16; n++) begin
            wait_idle();
            arm(32'h9000, 4'd15);
            for (int r = 0; r < 16; r++) begin
                wait_irq();
                if (n == 15 && r == 15) check("wr_before", bus.ack_count, 255);
                do_ack(32'h7F20, 4'b0001);
            end
        end
        check("wr_after", bus.ack_count, 0);
        check("wr_irq", bus.interrupt, 0);
        check("wr_no_err", bus.timeout_err, 0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/int_responder.md
# int_responder

External interrupt source and acknowledge responder for the CPU's interrupt-acknowledge write port. It raises `interrupt` when the macroscopic PC reaches an armed trigger address and holds it until the CPU writes the interrupt-acknowledge address through `m_int_addr`/`m_int_byteen`. It then repeats for a programmed number of occurrences. It sits beside the `mips` top in the testbench/SoC shell, driving the top's `interrupt` input and consuming its `macroscopic_pc`, `m_int_addr` and `m_int_byteen` outputs.

## Interface
Parameters:
- `INT_ADDR`, default 32'h0000_7F20: interrupt-acknowledge word address; bits [1:0] are ignored.
- `GAP`, default 4: cooldown cycles after each ack before re-arming; range 0..255.
- `TIMEOUT`, default 1024: cycles in ASSERT without an ack before abort; range 1..65535.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `arm_valid`  in  1  a trigger load request is valid.
- `arm_ready`  out  1  the block accepts a load; high only in IDLE.
- `arm_pc`  in  32  trigger PC.
- `arm_repeat`  in  4  number of interrupts minus 1 (0 means one interrupt, 15 means sixteen).
- `macroscopic_pc`  in  32  committed PC from the CPU.
- `m_int_addr`  in  32  interrupt-acknowledge write address from the CPU.
- `m_int_byteen`  in  4  interrupt-acknowledge byte enables.
- `interrupt`  out  1  registered interrupt request to the CPU.
- `busy`  out  1  the state is not IDLE.
- `ack_count`  out  8  count of accepted acks; wraps 255→0.
- `timeout_err`  out  1  sticky abort flag; only reset clears it.

## Operation
- Ack condition: `m_int_byteen != 0` and `m_int_addr[31:2] == INT_ADDR[31:2]`.
- IDLE:
  - `arm_ready`=1.
  - On `arm_valid & arm_ready`: latch `arm_pc` into pc_r and `arm_repeat` into rem_r, then go to ARMED.
- ARMED:
  - When `macroscopic_pc == pc_r`, go to ASSERT and set `interrupt` to 1.
  - No other exit.
- ASSERT:
  - `interrupt` holds at 1 and the timeout counter increments each cycle.
  - On ack:
    - `interrupt` goes to 0 and `ack_count` increments.
    - If `GAP > 0`, go to GAP.
    - If `GAP == 0`: go to ARMED when rem_r != 0, otherwise go to IDLE.
    - rem_r decrements when it is nonzero.
  - On timeout (counter == TIMEOUT-1 with no ack):
    - `interrupt` goes to 0 and `timeout_err` is set to 1.
    - Go to IDLE; the remaining repeats are discarded.
- GAP:
  - Count GAP cycles.
  - On the last cycle, go to ARMED when rem_r != 0, otherwise go to IDLE.
- An ack outside ASSERT is ignored: no count, no state change.
- The same PC must match again after re-arming. If `macroscopic_pc` already equals pc_r on entry to ARMED, the match fires in that cycle.
- `arm_valid` while not IDLE is ignored; it is not queued.

## Timing
- Reset values: `interrupt`=0, `busy`=0, `arm_ready`=1, `ack_count`=0, `timeout_err`=0, state=IDLE, all counters 0.
- Reset takes effect immediately, independent of `clk`, including mid-ASSERT: `interrupt` drops asynchronously.
- Arm handshake: accepted at edge T; `busy`=1 and `arm_ready`=0 from T.
- Match seen in the cycle before edge T+k: `interrupt`=1 from edge T+k. Latency is 1 cycle from PC match.
- Ack sampled at edge A: `interrupt`=0 and `ack_count` updated from A. The CPU therefore sees `interrupt` for at least 1 cycle.
- GAP: exactly GAP cycles in the GAP state, then ARMED. The earliest re-assert is GAP+1 cycles after ack edge A.
- Timeout: with no ack, `interrupt` is high for exactly TIMEOUT cycles.
- Ack and timeout in the same cycle: ack wins; no error.
- `busy` falls at the edge that enters IDLE.
- `ack_count` wrap: 255 + 1 → 0, with no flag.

## Configuration
- `INT_RESP_TIMEOUT_EN` defined:
  - The timeout counter and `timeout_err` logic are built.
  - Behaviour is as described above.
- `INT_RESP_TIMEOUT_EN` undefined:
  - No timeout counter is built.
  - ASSERT waits for an ack indefinitely.
  - `timeout_err` is tied to 0.
  - The `TIMEOUT` parameter is unused.

## Test plan
- Single shot:
  - Stimulus: arm pc=0x3008, repeat=0; drive `macroscopic_pc`=0x3008 at cycle 10; ack (addr 0x7F20, byteen 4'b0001) at cycle 15.
  - Required: `interrupt` high cycles 11–15, 0 from the ack edge; `ack_count`=1; `busy`=0 after GAP=4 cycles.
- Repeat:
  - Stimulus: arm repeat=2; PC matches three times, each acked.
  - Required: exactly 3 pulses; `ack_count`=3; each re-assert no earlier than 5 cycles after the previous ack; then IDLE.
- Spurious and mismatched acks:
  - Stimulus: ack write in ARMED; a write to 0x7F24 in ASSERT; byteen=0 at 0x7F20 in ASSERT.
  - Required: no effect; `interrupt` stays at its current value.
- Timeout (TIMEOUT=8, macro defined):
  - Stimulus: match with no ack.
  - Required: `interrupt` high exactly 8 cycles; `timeout_err`=1 and stays 1; state IDLE; the remaining repeat is dropped.
- Ack at the timeout boundary:
  - Stimulus: ack on the 8th ASSERT cycle.
  - Required: `timeout_err`=0; `ack_count` increments.
- Async reset mid-ASSERT:
  - Stimulus: pull `reset` low between clock edges.
  - Required: `interrupt`=0 immediately; all outputs at reset values; `arm_ready`=1 after release.
